regfile_wb_arbiter: RTL and testbench

- Controls the register file's single write port (regwrite/rd/wd).
- Shares the port between N_REQ writeback requesters (ALU, load unit, ...) using round-robin arbitration with a valid/ready handshake.
- Sequences a zero-clear of all 32 architectural registers after reset and on request.
- Sits between the execute/memory writeback sources and registerfile. Its registered outputs drive the registerfile write inputs directly.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {CLEAR, RUN} wb_state_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request after ptr_i (wrapping).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o
);

  always_comb begin
    logic found;
    int   j;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    // Scan starts one past the last winner, so the last winner is considered last.
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (en_i && req_i[j] && !found) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin writeback arbitration plus a 32-entry zero-clear sequencer.
// Optional macro REGFILE_WB_FWD_EN adds combinational forwarding of the pending write to two read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*REG_ADDR_W-1:0] req_rd_i,
  input  logic [N_REQ*XLEN-1:0]       req_wd_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic                        clear_req_i,
  output logic                        busy_o,
  output logic                        regwrite_o,
  output logic [REG_ADDR_W-1:0]       rd_o,
  output logic [XLEN-1:0]             wd_o
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0]       rs1_i,
  input  logic [REG_ADDR_W-1:0]       rs2_i,
  output logic                        fwd_a_valid_o,
  output logic                        fwd_b_valid_o,
  output logic [XLEN-1:0]             fwd_a_o,
  output logic [XLEN-1:0]             fwd_b_o
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: requester i holds req_valid_i[i], rd and wd stable until req_ready_o[i];
  // a transfer happens in any cycle where both are high, and lands on the outputs one edge later.

  wb_state_e         state_q, state_d;
  reg_addr_t         clr_cnt_q, clr_cnt_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              regwrite_q, regwrite_d;
  reg_addr_t         rd_q, rd_d;
  logic [XLEN-1:0]   wd_q, wd_d;

  logic [N_REQ-1:0]  gnt;
  logic [PW-1:0]     gnt_idx;
  logic              arb_en;
  reg_addr_t         req_rd   [N_REQ];
  logic [XLEN-1:0]   req_wd   [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_rd[g] = req_rd_i[g*REG_ADDR_W +: REG_ADDR_W];
    assign req_wd[g] = req_wd_i[g*XLEN +: XLEN];
  end

  // A clear request pre-empts arbitration in the cycle it arrives.
  assign arb_en = (state_q == RUN) && !clear_req_i;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr_arbiter (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign busy_o      = (state_q == CLEAR);
  assign regwrite_o  = regwrite_q;
  assign rd_o        = rd_q;
  assign wd_o        = wd_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      rr_ptr_q   <= PW'(N_REQ - 1);
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wd_d       = wd_q;
    case (state_q)
      CLEAR: begin
        regwrite_d = 1'b1;
        rd_d       = clr_cnt_q;
        wd_d       = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == reg_addr_t'(NUM_REGS - 1)) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end
      end
      RUN: begin
        if (clear_req_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (|gnt) begin
          // x0 writes still consume the request but never assert the enable.
          regwrite_d = (req_rd[gnt_idx] != '0);
          rd_d       = req_rd[gnt_idx];
          wd_d       = req_wd[gnt_idx];
          rr_ptr_d   = gnt_idx;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

`ifdef REGFILE_WB_FWD_EN
  assign fwd_a_valid_o = regwrite_q && (rs1_i == rd_q) && (rs1_i != '0);
  assign fwd_b_valid_o = regwrite_q && (rs2_i == rd_q) && (rs2_i != '0);
  assign fwd_a_o       = wd_q;
  assign fwd_b_o       = wd_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter with a transaction-level reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]      req_valid;
  logic [4:0]        rd_in [N];
  logic [31:0]       wd_in [N];
  logic [N*5-1:0]    req_rd;
  logic [N*32-1:0]   req_wd;
  logic [N-1:0]      req_ready_o;
  logic              clr;
  logic              busy_o, regwrite_o;
  logic [4:0]        rd_o;
  logic [31:0]       wd_o;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]        rs1, rs2;
  logic              fwd_a_valid_o, fwd_b_valid_o;
  logic [31:0]       fwd_a_o, fwd_b_o;
`endif

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_rd[g*5 +: 5]   = rd_in[g];
    assign req_wd[g*32 +: 32] = wd_in[g];
  end

  regfile_wb_arbiter #(.N_REQ(N)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .req_valid_i  (req_valid),
    .req_rd_i     (req_rd),
    .req_wd_i     (req_wd),
    .req_ready_o  (req_ready_o),
    .clear_req_i  (clr),
    .busy_o       (busy_o),
    .regwrite_o   (regwrite_o),
    .rd_o         (rd_o),
    .wd_o         (wd_o)
`ifdef REGFILE_WB_FWD_EN
    ,
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .fwd_a_valid_o(fwd_a_valid_o),
    .fwd_b_valid_o(fwd_b_valid_o),
    .fwd_a_o      (fwd_a_o),
    .fwd_b_o      (fwd_b_o)
`endif
  );

  // scoreboard counters
  int total  = 0;
  int passed = 0;
  int failed = 0;

  // reference model: clear progress, last winner, expected write-port contents
  bit          m_busy;
  int          m_cnt;
  int          m_last;
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [N-1:0] last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b1;
    m_cnt  = 0;
    m_last = N - 1;
    m_rw   = 1'b0;
    m_rd   = '0;
    m_wd   = '0;
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    bit found;
    int i;
    g = '0;
    found = 1'b0;
    if (!m_busy && !clr) begin
      for (int k = 1; k <= N; k++) begin
        i = (m_last + k) % N;
        if (req_valid[i] && !found) begin
          g[i]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

  // Called just after a falling edge with inputs settled; checks one full cycle.
  task automatic cycle(input string tag);
    logic [N-1:0] g;
    g = model_grant();
    #1;
    chk({tag, "_ready"}, 32'(req_ready_o), 32'(g));
    if (m_busy) begin
      m_rw = 1'b1;
      m_rd = 5'(m_cnt);
      m_wd = '0;
      m_cnt++;
      if (m_cnt == NUM_REGS) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end
    end else if (clr) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      m_rw   = 1'b0;
    end else if (g != '0) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_rw   = (rd_in[i] != 5'd0);
          m_rd   = rd_in[i];
          m_wd   = wd_in[i];
          m_last = i;
        end
      end
    end else begin
      m_rw = 1'b0;
    end
    last_gnt = g;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_regwrite"}, 32'(regwrite_o), 32'(m_rw));
    chk({tag, "_rd"},       32'(rd_o),       32'(m_rd));
    chk({tag, "_wd"},       wd_o,            m_wd);
    chk({tag, "_busy"},     32'(busy_o),     32'(m_busy));
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    clr       = 1'b0;
    model_reset();
    #1;
    chk("rst_regwrite", 32'(regwrite_o), 32'd0);
    chk("rst_rd",       32'(rd_o),       32'd0);
    chk("rst_wd",       wd_o,            32'd0);
    chk("rst_busy",     32'(busy_o),     32'd1);
    chk("rst_ready",    32'(req_ready_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rd_in[i] = '0;
      wd_in[i] = '0;
    end
`ifdef REGFILE_WB_FWD_EN
    rs1 = '0;
    rs2 = '0;
`endif
    apply_reset();

    // Post-reset clear: 32 zero writes, then RUN
    for (int c = 0; c < 33; c++) cycle("clear");
    chk("clear_done_busy", 32'(busy_o), 32'd0);

    // Both requesters hammering: alternating grants starting with 0
    req_valid = 2'b11;
    rd_in[0] = 5'd5; wd_in[0] = 32'h1111_1111;
    rd_in[1] = 5'd6; wd_in[1] = 32'h2222_2222;
    for (int c = 0; c < 4; c++) begin
      cycle("alt");
      chk("alt_winner", 32'(last_gnt), (c % 2 == 0) ? 32'd1 : 32'd2);
    end

    // x0 write: handshake completes, enable stays low
    req_valid = 2'b01;
    rd_in[0] = 5'd0; wd_in[0] = 32'hDEAD_BEEF;
    cycle("x0");
    chk("x0_regwrite", 32'(regwrite_o), 32'd0);

    // Clear request while req0 holds a write to x7
    rd_in[0] = 5'd9; wd_in[0] = 32'h0000_0099;
    cycle("pre_clr");
    rd_in[0] = 5'd7; wd_in[0] = 32'h0000_0077;
    clr = 1'b1;
    cycle("clr_pulse");
    clr = 1'b0;
    for (int c = 0; c < 32; c++) cycle("reclear");
    cycle("x7_first_run");
    chk("x7_rd", 32'(rd_o), 32'd7);
    req_valid = '0;

    // Reset in the middle of a clear sequence
    clr = 1'b1;
    cycle("clr_for_reset");
    clr = 1'b0;
    for (int c = 0; c < 10; c++) cycle("mid_clear");
    @(posedge clk);
    #1;
    chk("pre_async_rd", 32'(rd_o), 32'd10);
    #1 rst = 1'b1;
    #1;
    chk("async_regwrite", 32'(regwrite_o), 32'd0);
    chk("async_rd",       32'(rd_o),       32'd0);
    chk("async_busy",     32'(busy_o),     32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle("restart");
    chk("restart_rd0", 32'(rd_o), 32'd0);
    for (int c = 0; c < 32; c++) cycle("restart_clear");

`ifdef REGFILE_WB_FWD_EN
    req_valid = 2'b01;
    rd_in[0] = 5'd3; wd_in[0] = 32'hCAFE_0001;
    rs1 = 5'd3; rs2 = 5'd0;
    cycle("fwd");
    chk("fwd_a_valid", 32'(fwd_a_valid_o), 32'd1);
    chk("fwd_a",       fwd_a_o,            32'hCAFE_0001);
    chk("fwd_b_valid", 32'(fwd_b_valid_o), 32'd0);
    req_valid = '0;
    cycle("fwd_idle");
    chk("fwd_idle_a_valid", 32'(fwd_a_valid_o), 32'd0);
`endif

    // Randomized traffic with requesters holding until accepted
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          rd_in[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          wd_in[i] = $urandom;
        end
      end
      clr = ($urandom_range(0, 59) == 0);
      cycle("rand");
      clr = 1'b0;
      for (int i = 0; i < N; i++) if (last_gnt[i]) req_valid[i] = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
